// File: rtl/uart_rx_frame_assembler_pkg.sv
// Shared UART receive constants, FSM state encoding and width helper for the
// frame assembler and its byte receiver.
package uart_rx_frame_assembler_pkg;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    // Bits needed to hold values 0..value-1 (0 for value <= 1).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: two-flop synchroniser, baud counter and the
// IDLE/START/DATA/STOP/WAIT_HIGH FSM; flags each accepted byte or bad stop bit.
module uart_rx_byte
    import uart_rx_frame_assembler_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_ser,
    output logic [DATA_BITS-1:0] o_byte_data,
    output logic                 o_byte_valid,
    output logic                 o_stop_err,
    output logic                 o_busy
);

    localparam int BAUD_W = clog2(CLKS_PER_BIT);
    localparam int BIT_W  = clog2(DATA_BITS);
    localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BAUD_W-1:0] BAUD_FULL = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    rx_state_t             r_state, w_state_next;
    logic                  r_sync1, r_rx;
    logic [BAUD_W-1:0]     r_baud, w_baud_next;
    logic [BIT_W-1:0]      r_bit, w_bit_next;
    logic [DATA_BITS-1:0]  r_shift, w_shift_next;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_rx    <= 1'b1;
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_sync1 <= i_ser;
            r_rx    <= r_sync1;
            r_state <= w_state_next;
            r_baud  <= w_baud_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
        end
    end

    // NOTE: every signal driven here is defaulted first, so no path infers a latch.
    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        o_byte_valid = 1'b0;
        o_stop_err   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!r_rx) begin
                    w_state_next = START;
                    w_baud_next  = '0;
                end
            end
            START: begin
                if (r_baud == BAUD_HALF) begin
                    w_baud_next  = '0;
                    w_bit_next   = '0;
                    w_state_next = r_rx ? IDLE : DATA;
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end
            DATA: begin
                if (r_baud == BAUD_FULL) begin
                    w_baud_next  = '0;
                    w_shift_next = {r_rx, r_shift[DATA_BITS-1:1]};
                    if (r_bit == DATA_LAST) begin
                        w_bit_next   = '0;
                        w_state_next = STOP;
                    end else begin
                        w_bit_next = r_bit + 1'b1;
                    end
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end
            STOP: begin
                if (r_baud == BAUD_FULL) begin
                    w_baud_next = '0;
                    if (!r_rx) begin
                        o_stop_err   = 1'b1;
                        w_state_next = WAIT_HIGH;
                    end else if (r_bit == STOP_LAST) begin
                        o_byte_valid = 1'b1;
                        w_state_next = IDLE;
                    end else begin
                        w_bit_next = r_bit + 1'b1;
                    end
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end
            WAIT_HIGH: begin
                // A held-low line (break) must not look like a fresh start bit.
                if (r_rx) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign o_byte_data = r_shift;
    assign o_busy      = (r_state != IDLE);

endmodule

// File: rtl/uart_rx_frame_assembler.sv
// Packs BYTES_TO_RECEIVE UART bytes into one frame bus with a one-cycle valid.
// Optional idle timeout for partial frames is enabled with macro RX_TIMEOUT_EN.
module uart_rx_frame_assembler
    import uart_rx_frame_assembler_pkg::*;
#(
    parameter int CLKS_PER_BIT     = 16,
    parameter int BYTES_TO_RECEIVE = 16,
    parameter int TIMEOUT_BITS     = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ser_in,
    output logic [BYTES_TO_RECEIVE*8-1:0] bus_SERDES,
    output logic                          valid_in,
    output logic                          busy,
    output logic                          frame_err
);

    localparam int FRAME_W = BYTES_TO_RECEIVE * DATA_BITS;
    localparam int CNT_W   = clog2(BYTES_TO_RECEIVE + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BYTES_TO_RECEIVE - 1);

    logic [DATA_BITS-1:0] w_byte_data;
    logic                 w_byte_valid;
    logic                 w_stop_err;
    logic                 w_busy;
    logic                 w_timeout;
    logic [FRAME_W-1:0]   r_acc, w_acc_next;
    logic [CNT_W-1:0]     r_byte_cnt;
    logic [FRAME_W-1:0]   r_bus;
    logic                 r_valid;
    logic                 r_frame_err;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk          (clk),
        .reset        (reset),
        .i_ser        (ser_in),
        .o_byte_data  (w_byte_data),
        .o_byte_valid (w_byte_valid),
        .o_stop_err   (w_stop_err),
        .o_busy       (w_busy)
    );

`ifdef RX_TIMEOUT_EN
    localparam int TIMEOUT_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TO_W           = clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] r_idle_cnt;

    // Runs only while idle with a partial frame held; any start detection leaves IDLE and clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idle_cnt <= '0;
        end else if (w_busy || (r_byte_cnt == '0) || w_timeout) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end

    assign w_timeout = !w_busy && (r_byte_cnt != '0) && (r_idle_cnt == TO_W'(TIMEOUT_CYCLES));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_acc_next = r_acc;
        for (int k = 0; k < BYTES_TO_RECEIVE; k++) begin
            if (r_byte_cnt == CNT_W'(k)) begin
                w_acc_next[k*DATA_BITS +: DATA_BITS] = w_byte_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc       <= '0;
            r_byte_cnt  <= '0;
            r_bus       <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_stop_err || w_timeout) begin
                r_byte_cnt  <= '0;
                r_frame_err <= 1'b1;
            end else if (w_byte_valid) begin
                r_acc <= w_acc_next;
                if (r_byte_cnt == LAST_IDX) begin
                    r_bus      <= w_acc_next;
                    r_valid    <= 1'b1;
                    r_byte_cnt <= '0;
                end else begin
                    r_byte_cnt <= r_byte_cnt + 1'b1;
                end
            end
        end
    end

    assign bus_SERDES = r_bus;
    assign valid_in   = r_valid;
    assign busy       = w_busy;
    assign frame_err  = r_frame_err;

endmodule
